sprite_blit_engine: RTL and testbench

- Parametrised sprite renderer for the VGA frame-buffer path; successor to the fixed 16x16 single-sprite controller.
- Holds one sprite bitmap (SPR_W x SPR_H) in internal RAM and a current position.
- Executes DRAW, ERASE, MOVE and LOAD commands via a valid/ready command port.
- Streams (x, y, colour) pixel writes to the frame-buffer writer with backpressure, clipping to screen bounds.

---
 rtl/sprite_blit_engine_if.sv | 42 ++++
 rtl/sprite_blit_engine.sv | 165 ++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blit_engine_if.sv
// Command, sprite-RAM write and pixel-stream signals of the sprite blit engine.
// master = host / frame-buffer side, slave = engine side.
interface sprite_blit_engine_if #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned COL_W = 12,
  parameter int unsigned SPR_W = 16,
  parameter int unsigned SPR_H = 16
);
  localparam int unsigned AW = $clog2(SPR_W * SPR_H);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [X_W-1:0]   cmd_dx;
  logic [Y_W-1:0]   cmd_dy;
  logic [X_W-1:0]   cmd_x;
  logic [Y_W-1:0]   cmd_y;
  logic             spr_we;
  logic [AW-1:0]    spr_waddr;
  logic [COL_W-1:0] spr_wdata;
  logic             pix_valid;
  logic             pix_ready;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic [COL_W-1:0] pix_colour;
  logic             done;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;

  modport master (
    output cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_x, cmd_y,
    output spr_we, spr_waddr, spr_wdata, pix_ready,
    input  cmd_ready, pix_valid, pix_x, pix_y, pix_colour, done, pos_x, pos_y
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dx, cmd_dy, cmd_x, cmd_y,
    input  spr_we, spr_waddr, spr_wdata, pix_ready,
    output cmd_ready, pix_valid, pix_x, pix_y, pix_colour, done, pos_x, pos_y
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Single-sprite blitter: DRAW / ERASE / MOVE / LOAD with clipped, backpressured pixel stream.
// Optional colour-key transparency in DRAW when SPRITE_TRANSPARENT_EN is defined.
module sprite_blit_engine #(
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned COL_W     = 12,
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned BG_COLOUR = 0,
  parameter int unsigned INIT_X    = 72,
  parameter int unsigned INIT_Y    = 52
`ifdef SPRITE_TRANSPARENT_EN
  ,
  parameter logic [COL_W-1:0] KEY_COLOUR = 12'hF0F
`endif
) (
  input logic                 clk,
  input logic                 reset,
  sprite_blit_engine_if.slave bus
);
  localparam int unsigned AW = $clog2(SPR_W * SPR_H);
  localparam int unsigned CW = $clog2(SPR_W);

  typedef enum logic [1:0] {StIdle, StErase, StDraw, StDone} state_e;

  state_e           state_q, state_d;
  logic             move_q, move_d;
  logic             drain_q, drain_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d, tgt_x_q, tgt_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d, tgt_y_q, tgt_y_d;
  logic             pv_q, pv_d;
  logic [X_W-1:0]   px_q, px_d;
  logic [Y_W-1:0]   py_q, py_d;
  logic [COL_W-1:0] pc_q, pc_d;

  logic [COL_W-1:0] ram [SPR_W * SPR_H];
  logic [COL_W-1:0] ram_rd;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic             skip;
  logic             out_free;

  // Asynchronous read: a same-cycle write is seen only from the next cycle on.
  always_ff @(posedge clk) begin
    if (bus.spr_we) ram[bus.spr_waddr] <= bus.spr_wdata;
  end

  assign ram_rd   = ram[ptr_q];
  assign cur_x    = pos_x_q + X_W'(ptr_q[CW-1:0]);
  assign cur_y    = pos_y_q + Y_W'(ptr_q[AW-1:CW]);
  assign out_free = !pv_q || bus.pix_ready;

  always_comb begin
    skip = (32'(cur_x) >= SCREEN_W) || (32'(cur_y) >= SCREEN_H);
`ifdef SPRITE_TRANSPARENT_EN
    if (state_q == StDraw && ram_rd == KEY_COLOUR) skip = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    move_d  = move_q;
    drain_d = drain_q;
    ptr_d   = ptr_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    pv_d    = pv_q && !bus.pix_ready;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          move_d = 1'b0;
          case (bus.cmd_op)
            2'd0: state_d = StDraw;
            2'd1: state_d = StErase;
            2'd2: begin
              state_d = StErase;
              move_d  = 1'b1;
              tgt_x_d = pos_x_q + bus.cmd_dx;
              tgt_y_d = pos_y_q + bus.cmd_dy;
            end
            2'd3: begin
              state_d = StDone;
              pos_x_d = bus.cmd_x;
              pos_y_d = bus.cmd_y;
            end
          endcase
        end
      end
      StErase, StDraw: begin
        if (drain_q) begin
          // Last pixel is in the output register; leave once it has gone.
          if (out_free) begin
            drain_d = 1'b0;
            if (state_q == StErase && move_q) begin
              state_d = StDraw;
              move_d  = 1'b0;
              pos_x_d = tgt_x_q;
              pos_y_d = tgt_y_q;
            end else begin
              state_d = StDone;
            end
          end
        end else if (skip || out_free) begin
          ptr_d = ptr_q + AW'(1);
          if (&ptr_q) drain_d = 1'b1;
          if (!skip) begin
            pv_d = 1'b1;
            px_d = cur_x;
            py_d = cur_y;
            pc_d = (state_q == StDraw) ? ram_rd : COL_W'(BG_COLOUR);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      move_q  <= 1'b0;
      drain_q <= 1'b0;
      ptr_q   <= '0;
      pos_x_q <= X_W'(INIT_X);
      pos_y_q <= Y_W'(INIT_Y);
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      move_q  <= move_d;
      drain_q <= drain_d;
      ptr_q   <= ptr_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.pix_valid  = pv_q;
  assign bus.pix_x      = px_q;
  assign bus.pix_y      = py_q;
  assign bus.pix_colour = pc_q;
  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomised bench for sprite_blit_engine: expected pixel stream built per command from
// screen-space arithmetic, scoreboarded against every transfer.
module tb_sprite_blit_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_blit_engine_if bus ();
  sprite_blit_engine dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] c;
  } px_t;

  px_t         exp_q[$];
  logic [11:0] mram [256];
  int          mx, my;
  int          vectors = 0, errors = 0;
  int          cyc = 0;
  int          acc_cyc, done_cyc, first_pv_cyc, px_cnt, rdy_mode;
  bit          want_first;
  px_t         first_px, last_px;
  logic [14:0] pos_prev;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) pos_prev <= {bus.pos_x, bus.pos_y};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected stream of one DRAW/ERASE pass with its base at (bx, by).
  task automatic gen(input int bx, input int by, input bit draw);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        px_t p;
        p.x = 8'((bx + c) & 255);
        p.y = 7'((by + r) & 127);
        p.c = draw ? mram[r * 16 + c] : 12'h000;
        if (int'(p.x) >= 160 || int'(p.y) >= 120) continue;
`ifdef SPRITE_TRANSPARENT_EN
        if (draw && mram[r * 16 + c] == 12'hF0F) continue;
`endif
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic wr(input int addr, input logic [11:0] d);
    bus.spr_we    = 1'b1;
    bus.spr_waddr = 8'(addr);
    bus.spr_wdata = d;
    mram[addr]    = d;
    @(posedge clk); #1;
    bus.spr_we = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int a, input int b, input bit hold_busy);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      vectors++; errors++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1");
      return;
    end
    case (op)
      0: gen(mx, my, 1'b1);
      1: gen(mx, my, 1'b0);
      2: begin
        gen(mx, my, 1'b0);
        mx = (mx + a) & 255;
        my = (my + b) & 127;
        gen(mx, my, 1'b1);
      end
      default: begin
        mx = a & 255;
        my = b & 127;
      end
    endcase
    @(posedge clk); #1;
    px_cnt        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_dx    = a[7:0];
    bus.cmd_x     = a[7:0];
    bus.cmd_dy    = b[6:0];
    bus.cmd_y     = b[6:0];
    @(posedge clk); #1;
    if (hold_busy) begin
      // A LOAD presented while busy must be ignored.
      bus.cmd_op = 2'd3;
      bus.cmd_x  = 8'd3;
      bus.cmd_y  = 7'd3;
      repeat (30) @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      vectors++; errors++;
      $display("FAIL done_timeout: got 0, expected 1");
      return;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("pos_at_done", {bus.pos_x, bus.pos_y}, {mx[7:0], my[6:0]});
    if (op != 3) chk("pos_before_done", pos_prev, {mx[7:0], my[6:0]});
    chk("ready_in_done", bus.cmd_ready, 1'b0);
    @(negedge clk);
    chk("done_pulse_end", {bus.done, bus.cmd_ready}, 2'b01);
  endtask

  // Ready driver.
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.pix_ready = 1'b1;
        1:       bus.pix_ready = !bus.pix_ready;
        default: bus.pix_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare process: scoreboard every transfer and check holding under backpressure.
  initial begin
    logic pv_p, pr_p;
    logic [26:0] out_p;
    pv_p = 1'b0; pr_p = 1'b0; out_p = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv_p = 1'b0;
        continue;
      end
      if (pv_p && !pr_p)
        chk("stall_hold", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_colour}, {1'b1, out_p});
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc    = cyc;
        want_first = 1'b1;
      end
      if (bus.pix_valid && want_first) begin
        first_pv_cyc = cyc;
        want_first   = 1'b0;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        px_t got;
        got = {bus.pix_x, bus.pix_y, bus.pix_colour};
        if (px_cnt == 0) first_px = got;
        last_px = got;
        px_cnt++;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL extra_pixel: got 0x%0h, expected none", got);
        end else begin
          chk("pixel", got, exp_q.pop_front());
        end
      end
      if (bus.done) done_cyc = cyc;
      pv_p  = bus.pix_valid;
      pr_p  = bus.pix_ready;
      out_p = {bus.pix_x, bus.pix_y, bus.pix_colour};
    end
  end

  initial begin
    reset = 1'b1;
    rdy_mode = 0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_dx = '0; bus.cmd_dy = '0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.spr_we = 1'b0; bus.spr_waddr = '0; bus.spr_wdata = '0;
    mx = 72; my = 52;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {bus.cmd_ready, bus.pix_valid, bus.done}, 3'b100);
    chk("reset_pix", {bus.pix_x, bus.pix_y, bus.pix_colour}, 27'd0);
    chk("reset_pos", {bus.pos_x, bus.pos_y}, {8'd72, 7'd52});
    reset = 1'b0;

    // Solid sprite at the reset position.
    for (int i = 0; i < 256; i++) wr(i, 12'hFFF);
    run_cmd(0, 0, 0, 1'b0);
    chk("draw_count", 64'(px_cnt), 64'd256);
    chk("draw_first_pv_lat", 64'(first_pv_cyc - acc_cyc), 64'd2);
    chk("draw_done_lat", 64'(done_cyc - acc_cyc), 64'd258);
    chk("draw_first_px", first_px, {8'd72, 7'd52, 12'hFFF});
    chk("draw_last_px", last_px, {8'd87, 7'd67, 12'hFFF});

    run_cmd(2, 4, 0, 1'b0);
    chk("move_count", 64'(px_cnt), 64'd512);
    chk("move_pos", {bus.pos_x, bus.pos_y}, {8'd76, 7'd52});
    chk("move_last_px", last_px, {8'd91, 7'd67, 12'hFFF});

    run_cmd(3, 150, 110, 1'b0);
    chk("load_count", 64'(px_cnt), 64'd0);
    run_cmd(0, 0, 0, 1'b0);
    chk("clip_count", 64'(px_cnt), 64'd100);
    chk("clip_first_px", first_px, {8'd150, 7'd110, 12'hFFF});

    // Random (never key) colours, ready toggling, command poked while busy.
    for (int i = 0; i < 256; i++) wr(i, 12'($urandom) & 12'h7FF);
    run_cmd(3, 72, 52, 1'b0);
    rdy_mode = 1;
    run_cmd(0, 0, 0, 1'b1);
    chk("toggle_count", 64'(px_cnt), 64'd256);
    rdy_mode = 0;

    // Columns 8..15 wrap to x 0..7 and stay visible; the rest of the DRAW is clipped.
    run_cmd(2, -80, 0, 1'b0);
    chk("wrap_pos", {bus.pos_x, bus.pos_y}, {8'd248, 7'd52});
    chk("wrap_count", 64'(px_cnt), 64'd384);

    for (int i = 0; i < 256; i++) wr(i, (i < 16) ? 12'hF0F : 12'h00F);
    run_cmd(3, 72, 52, 1'b0);
    run_cmd(0, 0, 0, 1'b0);
`ifdef SPRITE_TRANSPARENT_EN
    chk("key_count", 64'(px_cnt), 64'd240);
`else
    chk("key_count", 64'(px_cnt), 64'd256);
`endif

    for (int it = 0; it < 20; it++) begin
      if (it % 5 == 0)
        for (int i = 0; i < 256; i++)
          wr(i, ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom));
      rdy_mode = $urandom_range(0, 2);
      run_cmd($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 127), 1'b0);
    end
    rdy_mode = 0;

    // Abort mid-DRAW.
    run_cmd(3, 10, 20, 1'b0);
    gen(mx, my, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_ctrl", {bus.cmd_ready, bus.pix_valid, bus.done}, 3'b100);
    chk("abort_pix", {bus.pix_x, bus.pix_y, bus.pix_colour}, 27'd0);
    chk("abort_pos", {bus.pos_x, bus.pos_y}, {8'd72, 7'd52});
    exp_q.delete();
    mx = 72; my = 52;
    @(posedge clk); #1;
    reset = 1'b0;
    run_cmd(0, 0, 0, 1'b0);
    chk("recover_count", 64'(px_cnt), 64'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
